mlp_hls_deadlock_report_collector: RTL and testbench

Sink-side companion to the per-dataflow-region deadlock monitors. It receives the `block` flag of each monitor and filters out transient stalls by requiring a persistence window. On a qualified deadlock it captures a report record (first blocking monitor index, mask, start cycle) and delivers it over a valid/ready interface to the debug/status logic. It then holds a sticky deadlock flag until software or the testbench clears it.

---
 rtl/mlp_hls_dbg_pkg.sv | 24 ++
 rtl/mlp_hls_lowest_set_idx.sv | 18 +
 rtl/mlp_hls_deadlock_report_collector.sv | 141 ++++++++++++++
 tb/tb_mlp_hls_deadlock_report_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_hls_dbg_pkg.sv
// Shared types and defaults for the HLS dataflow deadlock debug blocks.
package mlp_hls_dbg_pkg;

    localparam int DEF_NUM_MON     = 4;
    localparam int DEF_IDX_W       = 2;
    localparam int DEF_PERSIST_CYC = 16;
    localparam int DEF_CNT_W       = 32;

    // Collector sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_REPORT  = 2'd2,
        ST_LATCHED = 2'd3
    } dbg_state_e;

    // Report record as seen by the debug/status logic at default widths.
    typedef struct packed {
        logic [DEF_IDX_W-1:0]   idx;
        logic [DEF_NUM_MON-1:0] mask;
        logic [DEF_CNT_W-1:0]   cycle;
    } dbg_report_t;

endpackage

// File: rtl/mlp_hls_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of vec_i (0 when vec_i is zero).
module mlp_hls_lowest_set_idx #(
    parameter int W     = 4,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/mlp_hls_deadlock_report_collector.sv
// Collects monitor block flags, qualifies persistent stalls, and emits one
// report record over valid/ready, then holds a sticky deadlock flag until clear.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no block seen; waiting for the first block sample
// ST_QUALIFY | block seen on every cycle of the current run, counting
// ST_REPORT  | record captured, report_valid_o high until accepted
// ST_LATCHED | record delivered; deadlock flag held until clear_i
module mlp_hls_deadlock_report_collector
    import mlp_hls_dbg_pkg::*;
#(
    parameter int NUM_MON     = DEF_NUM_MON,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int PERSIST_CYC = DEF_PERSIST_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block_i,
    input  logic               clear_i,
    output logic               report_valid_o,
    input  logic               report_ready_i,
    output logic [IDX_W-1:0]   report_idx_o,
    output logic [NUM_MON-1:0] report_mask_o,
    output logic [CNT_W-1:0]   report_cycle_o,
    output logic               deadlock_flag_o,
    output logic [CNT_W-1:0]   cycle_count_o
);

    // pc only ever reaches PERSIST_CYC-1, so it needs clog2(PERSIST_CYC) bits.
    localparam int PC_W = (PERSIST_CYC > 1) ? $clog2(PERSIST_CYC) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERSIST_CYC - 1);

    dbg_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   start_q, start_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [IDX_W-1:0]   report_idx_q, report_idx_d;
    logic [NUM_MON-1:0] report_mask_q, report_mask_d;
    logic [CNT_W-1:0]   report_cycle_q, report_cycle_d;
    logic               deadlock_flag_q, deadlock_flag_d;
    logic [IDX_W-1:0]   low_idx;
    logic               any_blk;

    assign any_blk = |mon_block_i;

    mlp_hls_lowest_set_idx #(
        .W     (NUM_MON),
        .IDX_W (IDX_W)
    ) u_low_idx (
        .vec_i (mon_block_i),
        .idx_o (low_idx)
    );

    // Next-state, persistence counting and report capture.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        start_d         = start_q;
        report_idx_d    = report_idx_q;
        report_mask_d   = report_mask_q;
        report_cycle_d  = report_cycle_q;
        deadlock_flag_d = deadlock_flag_q;
        cycle_count_d   = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (any_blk) begin
                    pc_d    = PC_W'(1);
                    start_d = cycle_count_q;
                    if (PERSIST_CYC == 1) begin
                        report_mask_d   = mon_block_i;
                        report_idx_d    = low_idx;
                        report_cycle_d  = cycle_count_q;
                        deadlock_flag_d = 1'b1;
                        state_d         = ST_REPORT;
                    end else begin
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (!any_blk) begin
                    pc_d    = '0;
                    state_d = ST_IDLE;
                end else if (pc_q == PC_LAST) begin
                    report_mask_d   = mon_block_i;
                    report_idx_d    = low_idx;
                    report_cycle_d  = start_q;
                    deadlock_flag_d = 1'b1;
                    state_d         = ST_REPORT;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_REPORT: begin
                if (report_ready_i) state_d = ST_LATCHED;
            end
            ST_LATCHED: begin
                if (clear_i) begin
                    deadlock_flag_d = 1'b0;
                    pc_d            = '0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            pc_q            <= '0;
            start_q         <= '0;
            cycle_count_q   <= '0;
            report_idx_q    <= '0;
            report_mask_q   <= '0;
            report_cycle_q  <= '0;
            deadlock_flag_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            start_q         <= start_d;
            cycle_count_q   <= cycle_count_d;
            report_idx_q    <= report_idx_d;
            report_mask_q   <= report_mask_d;
            report_cycle_q  <= report_cycle_d;
            deadlock_flag_q <= deadlock_flag_d;
        end
    end

    assign report_valid_o  = (state_q == ST_REPORT);
    assign report_idx_o    = report_idx_q;
    assign report_mask_o   = report_mask_q;
    assign report_cycle_o  = report_cycle_q;
    assign deadlock_flag_o = deadlock_flag_q;
    assign cycle_count_o   = cycle_count_q;

endmodule

// File: tb/tb_mlp_hls_deadlock_report_collector.sv
// Directed bench for the deadlock report collector: default instance plus a
// 4-bit counter instance and a PERSIST_CYC=1 instance.
module tb_mlp_hls_deadlock_report_collector;

    logic        clock = 1'b0;
    logic        reset;

    // Default instance
    logic [3:0]  mon;
    logic        clr;
    logic        rdy;
    logic        vld;
    logic [1:0]  idx;
    logic [3:0]  mask;
    logic [31:0] rcyc;
    logic        flag;
    logic [31:0] cc;

    // CNT_W = 4 instance
    logic        s_vld, s_flag;
    logic [1:0]  s_idx;
    logic [3:0]  s_mask, s_rcyc, s_cc;

    // PERSIST_CYC = 1 instance
    logic [3:0]  p_mon;
    logic        p_rdy;
    logic        p_vld, p_flag;
    logic [1:0]  p_idx;
    logic [3:0]  p_mask;
    logic [31:0] p_rcyc, p_cc;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cc   = 0;
    int start_cc = 0;

    always #5 clock = ~clock;

    mlp_hls_deadlock_report_collector dut (
        .clock          (clock),
        .reset          (reset),
        .mon_block_i    (mon),
        .clear_i        (clr),
        .report_valid_o (vld),
        .report_ready_i (rdy),
        .report_idx_o   (idx),
        .report_mask_o  (mask),
        .report_cycle_o (rcyc),
        .deadlock_flag_o(flag),
        .cycle_count_o  (cc)
    );

    mlp_hls_deadlock_report_collector #(.CNT_W(4)) dut_sat (
        .clock          (clock),
        .reset          (reset),
        .mon_block_i    (4'b0000),
        .clear_i        (1'b0),
        .report_valid_o (s_vld),
        .report_ready_i (1'b1),
        .report_idx_o   (s_idx),
        .report_mask_o  (s_mask),
        .report_cycle_o (s_rcyc),
        .deadlock_flag_o(s_flag),
        .cycle_count_o  (s_cc)
    );

    mlp_hls_deadlock_report_collector #(.PERSIST_CYC(1)) dut_p1 (
        .clock          (clock),
        .reset          (reset),
        .mon_block_i    (p_mon),
        .clear_i        (1'b0),
        .report_valid_o (p_vld),
        .report_ready_i (p_rdy),
        .report_idx_o   (p_idx),
        .report_mask_o  (p_mask),
        .report_cycle_o (p_rcyc),
        .deadlock_flag_o(p_flag),
        .cycle_count_o  (p_cc)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock, then sample at the falling edge.
    task automatic tick();
        @(negedge clock);
        exp_cc++;
    endtask

    initial begin
        reset = 1'b1; mon = '0; clr = 1'b0; rdy = 1'b0; p_mon = '0; p_rdy = 1'b0;

        // 1. Reset
        repeat (3) @(negedge clock);
        chk("rst_valid", vld, 0);
        chk("rst_flag",  flag, 0);
        chk("rst_cc",    cc, 0);
        chk("rst_idx",   idx, 0);
        chk("rst_mask",  mask, 0);
        chk("rst_cycle", rcyc, 0);
        reset = 1'b0;
        exp_cc = 0;
        chk("cc0", cc, 0);
        tick();
        chk("cc1", cc, 1);
        tick();
        chk("cc2", cc, 2);
        chk("sat_cc2", s_cc, 2);

        // 6b. PERSIST_CYC=1: single block cycle reports next cycle
        p_mon = 4'b0100;
        start_cc = exp_cc;
        tick();
        p_mon = 4'b0000;
        chk("p1_valid", p_vld, 1);
        chk("p1_idx",   p_idx, 2);
        chk("p1_mask",  p_mask, 4'b0100);
        chk("p1_cycle", p_rcyc, start_cc);
        chk("p1_flag",  p_flag, 1);
        tick();
        chk("p1_valid_held", p_vld, 1);
        p_rdy = 1'b1;
        tick();
        chk("p1_valid_drop", p_vld, 0);
        chk("p1_flag_latched", p_flag, 1);

        // 2. Glitch rejection: 15 cycles of block is not enough
        mon = 4'b0010;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("glitch_valid", vld, 0);
        end
        mon = 4'b0000;
        tick();
        tick();
        chk("glitch_valid_after", vld, 0);
        chk("glitch_flag", flag, 0);

        // 2b. A full 16-cycle run is reported
        mon = 4'b0010;
        start_cc = exp_cc;
        repeat (15) tick();
        chk("run16_valid_pre", vld, 0);
        tick();
        chk("run16_valid", vld, 1);
        chk("run16_idx",   idx, 1);
        chk("run16_mask",  mask, 4'b0010);
        chk("run16_cycle", rcyc, start_cc);
        chk("run16_flag",  flag, 1);
        mon = 4'b0000;
        rdy = 1'b1;
        tick();
        chk("run16_accept", vld, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("run16_clear_flag", flag, 0);
        chk("sat_cc15", s_cc, 4'hF);

        // 3. Nominal report starting at cycle_count = 100
        while (exp_cc < 100) tick();
        chk("nom_cc100", cc, 100);
        mon = 4'b0110;
        repeat (15) tick();
        chk("nom_valid_pre", vld, 0);
        chk("nom_flag_pre",  flag, 0);
        tick();
        chk("nom_valid", vld, 1);
        chk("nom_idx",   idx, 1);
        chk("nom_mask",  mask, 4'b0110);
        chk("nom_cycle", rcyc, 100);
        chk("nom_flag",  flag, 1);
        tick();
        chk("nom_valid_one", vld, 0);
        chk("nom_flag_held", flag, 1);
        mon = 4'b0000;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("nom_clear", flag, 0);

        // 4. Backpressure with payload hold; 5a. clear during REPORT ignored
        rdy = 1'b0;
        mon = 4'b0110;
        start_cc = exp_cc;
        repeat (16) tick();
        chk("bp_valid", vld, 1);
        mon = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) clr = 1'b1;
            tick();
            clr = 1'b0;
            chk("bp_valid_hold", vld, 1);
            chk("bp_idx_hold",   idx, 1);
            chk("bp_mask_hold",  mask, 4'b0110);
            chk("bp_cycle_hold", rcyc, start_cc);
            chk("bp_flag_hold",  flag, 1);
        end
        rdy = 1'b1;
        tick();
        chk("bp_accept", vld, 0);
        chk("bp_latched_flag", flag, 1);
        tick();
        chk("bp_latched_ignore_blk", vld, 0);

        // 5b. Clear in LATCHED with block present: counting restarts after clear
        mon = 4'b0001;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_flag", flag, 0);
        chk("clr_valid", vld, 0);
        chk("clr_mask_kept", mask, 4'b0110);
        start_cc = exp_cc;
        repeat (15) tick();
        chk("clr_fresh_pre", vld, 0);
        tick();
        chk("clr_fresh_valid", vld, 1);
        chk("clr_fresh_idx",   idx, 0);
        chk("clr_fresh_mask",  mask, 4'b0001);
        chk("clr_fresh_cycle", rcyc, start_cc);

        // 6c. Reset mid-REPORT drops the report
        rdy = 1'b0;
        tick();
        chk("mid_valid_pre", vld, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_valid", vld, 0);
        chk("mid_rst_flag",  flag, 0);
        chk("mid_rst_mask",  mask, 0);
        chk("mid_rst_cycle", rcyc, 0);
        chk("mid_rst_cc",    cc, 0);
        chk("mid_rst_sat_cc", s_cc, 0);
        reset = 1'b0;
        mon = 4'b0000;
        exp_cc = 0;
        tick();
        chk("post_rst_cc", cc, 1);
        chk("post_rst_valid", vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
